// File: rtl/tt_mpu_seq.sv
// Matrix-unit instruction sequencer driving tt_opacc and VRF reads, returning LQ responses.
// Optional perf counters enabled with TT_MPU_SEQ_PERF_EN.
module tt_mpu_seq #(
  parameter int LQ_DEPTH_LOG2 = 3,
  parameter int VLEN          = 256,
  parameter int XLEN          = 64,
  parameter int NUM_MREGS     = 2,
  localparam int ROWS = VLEN / XLEN,
  localparam int MW   = (NUM_MREGS > 1) ? $clog2(NUM_MREGS) : 1,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_inst_vld,
  input  logic [31:0]              i_inst,
  input  logic [LQ_DEPTH_LOG2-1:0] i_lqid,
  output logic                     o_inst_rdy,
  output logic [2:0]               o_vrf_rden,
  output logic [14:0]              o_vrf_rdaddr,
  output logic                     o_ab_valid,
  output logic                     o_c_valid,
  output logic [MW-1:0]            o_op_addr,
  output logic [RW-1:0]            o_c_addr,
  output logic                     o_lqvld,
  output logic [LQ_DEPTH_LOG2-1:0] o_lqid,
  output logic                     o_lqexc,
  input  logic                     i_lq_rdy,
  output logic                     o_busy
`ifdef TT_MPU_SEQ_PERF_EN
  ,
  output logic [31:0]              o_perf_opacc_cnt,
  output logic [31:0]              o_perf_lq_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_EX, S_OUT, S_IN_RD, S_IN_WR, S_EXC
  } state_t;

  state_t                   state_q, state_d;
  logic [RW-1:0]            r_q, r_d;
  logic [MW-1:0]            md_q;
  logic [4:0]               vs1_q, vs2_q;
  logic [LQ_DEPTH_LOG2-1:0] lqid_q;

  logic [6:0]    opc;
  logic [2:0]    funct3;
  logic [4:0]    rd_f;
  logic [MW-1:0] md_in;
  logic          illegal;
  logic          accept;
  logic          last_row;
  logic          unused_inst;

  assign opc         = i_inst[6:0];
  assign funct3      = i_inst[14:12];
  assign rd_f        = i_inst[11:7];
  assign md_in       = i_inst[7 +: MW];
  assign unused_inst = ^i_inst[31:25];

  // bits of the rd field beyond the matrix-register index must be zero
  assign illegal = (opc != 7'h0B) || (funct3 > 3'd2) ||
                   (int'(md_in) >= NUM_MREGS) || ((rd_f >> MW) != 5'd0);

  assign o_inst_rdy = (state_q == S_IDLE);
  assign o_busy     = (state_q != S_IDLE);
  assign accept     = i_inst_vld & o_inst_rdy;
  assign last_row   = (r_q == RW'(ROWS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      md_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      lqid_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      if (accept) begin
        md_q   <= md_in;
        vs1_q  <= i_inst[19:15];
        vs2_q  <= i_inst[24:20];
        lqid_q <= i_lqid;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (i_inst_vld) begin
          r_d = '0;
          if (illegal)             state_d = S_EXC;
          else if (funct3 == 3'd0) state_d = S_RD;
          else if (funct3 == 3'd1) state_d = S_OUT;
          else                     state_d = S_IN_RD;
        end
      end
      S_RD: state_d = S_EX;
      S_EX: state_d = S_IDLE;
      S_OUT: begin
        if (i_lq_rdy) begin
          if (last_row) begin
            state_d = S_IDLE;
            r_d     = '0;
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      S_IN_RD: state_d = S_IN_WR;
      S_IN_WR: begin
        if (last_row) begin
          state_d = S_IDLE;
          r_d     = '0;
        end else begin
          state_d = S_IN_RD;
          r_d     = r_q + RW'(1);
        end
      end
      S_EXC: if (i_lq_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decode only flopped state and captured fields, never live inputs
  always_comb begin
    o_vrf_rden   = 3'b000;
    o_vrf_rdaddr = 15'd0;
    o_ab_valid   = 1'b0;
    o_c_valid    = 1'b0;
    o_op_addr    = '0;
    o_c_addr     = '0;
    o_lqvld      = 1'b0;
    o_lqid       = '0;
    o_lqexc      = 1'b0;
    case (state_q)
      S_RD: begin
        o_vrf_rden   = 3'b110;
        o_vrf_rdaddr = {vs1_q, vs2_q, 5'd0};
      end
      S_EX: begin
        o_ab_valid = 1'b1;
        o_op_addr  = md_q;
      end
      S_OUT: begin
        o_lqvld   = 1'b1;
        o_lqid    = lqid_q + LQ_DEPTH_LOG2'(r_q);
        o_c_addr  = r_q;
        o_op_addr = md_q;
      end
      S_IN_RD: begin
        o_vrf_rden   = 3'b001;
        o_vrf_rdaddr = {10'd0, vs1_q + 5'(r_q)};
      end
      S_IN_WR: begin
        o_c_valid = 1'b1;
        o_c_addr  = r_q;
        o_op_addr = md_q;
      end
      S_EXC: begin
        o_lqvld = 1'b1;
        o_lqexc = 1'b1;
        o_lqid  = lqid_q;
      end
      default: ;
    endcase
  end

`ifdef TT_MPU_SEQ_PERF_EN
  logic [31:0] perf_opacc_q, perf_stall_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      perf_opacc_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_opacc_q <= perf_opacc_q + {31'd0, o_ab_valid};
      perf_stall_q <= perf_stall_q + {31'd0, o_lqvld & ~i_lq_rdy};
    end
  end

  assign o_perf_opacc_cnt    = perf_opacc_q;
  assign o_perf_lq_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_tt_mpu_seq.sv
// Scoreboard bench for tt_mpu_seq: stimulus pushes expected output events, a monitor pops and compares.
module tb_tt_mpu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_vld;
  logic [31:0] inst;
  logic [2:0]  lqid;
  logic        inst_rdy;
  logic [2:0]  rden;
  logic [14:0] rdaddr;
  logic        ab_valid, c_valid;
  logic [0:0]  op_addr;
  logic [1:0]  c_addr;
  logic        lqvld;
  logic [2:0]  lqid_o;
  logic        lqexc;
  logic        lq_rdy;
  logic        busy;
`ifdef TT_MPU_SEQ_PERF_EN
  logic [31:0] perf_op, perf_st;
`endif

  always #5 clk = ~clk;

  tt_mpu_seq dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_inst_vld   (inst_vld),
    .i_inst       (inst),
    .i_lqid       (lqid),
    .o_inst_rdy   (inst_rdy),
    .o_vrf_rden   (rden),
    .o_vrf_rdaddr (rdaddr),
    .o_ab_valid   (ab_valid),
    .o_c_valid    (c_valid),
    .o_op_addr    (op_addr),
    .o_c_addr     (c_addr),
    .o_lqvld      (lqvld),
    .o_lqid       (lqid_o),
    .o_lqexc      (lqexc),
    .i_lq_rdy     (lq_rdy),
    .o_busy       (busy)
`ifdef TT_MPU_SEQ_PERF_EN
    ,
    .o_perf_opacc_cnt    (perf_op),
    .o_perf_lq_stall_cnt (perf_st)
`endif
  );

  typedef struct packed {
    logic [2:0]  rden;
    logic [14:0] addr;
    logic        ab;
    logic        cv;
    logic        lqv;
    logic        exc;
    logic [2:0]  id;
    logic        op;
    logic [1:0]  ca;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic ev_t ev_rd(input logic [2:0] r, input logic [14:0] a);
    ev_t e = '0;
    e.rden = r; e.addr = a;
    return e;
  endfunction

  function automatic ev_t ev_ab(input logic op);
    ev_t e = '0;
    e.ab = 1'b1; e.op = op;
    return e;
  endfunction

  function automatic ev_t ev_cv(input logic op, input logic [1:0] ca);
    ev_t e = '0;
    e.cv = 1'b1; e.op = op; e.ca = ca;
    return e;
  endfunction

  function automatic ev_t ev_lq(input logic exc, input logic [2:0] id, input logic op, input logic [1:0] ca);
    ev_t e = '0;
    e.lqv = 1'b1; e.exc = exc; e.id = id; e.op = op; e.ca = ca;
    return e;
  endfunction

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] md,
                                          input logic [4:0] vs1, input logic [4:0] vs2,
                                          input logic [6:0] opc);
    return {7'd0, vs2, vs1, f3, md, opc};
  endfunction

  // monitor: any strobe from the DUT must match the head of the expectation queue
  always @(negedge clk) begin
    ev_t act;
    ev_t exp;
    if (rden != 3'b000 || ab_valid || c_valid || lqvld) begin
      act = '{rden: rden, addr: rdaddr, ab: ab_valid, cv: c_valid, lqv: lqvld,
              exc: lqexc, id: lqid_o, op: op_addr, ca: c_addr};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event t=%0t actual=%h required=none", $time, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL event t=%0t actual=%h required=%h", $time, act, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] in, input logic [2:0] id);
    int n = 0;
    while (!inst_rdy && n < 50) begin
      n++;
      tick();
    end
    if (!inst_rdy) chk("wait_rdy", {31'd0, inst_rdy}, 32'd1);
    inst_vld = 1'b1;
    inst     = in;
    lqid     = id;
    tick();
    inst_vld = 1'b0;
    inst     = 32'd0;
    lqid     = 3'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
`ifdef TT_MPU_SEQ_PERF_EN
    logic [31:0] st0;
`endif
    rst_n    = 1'b0;
    inst_vld = 1'b1;
    inst     = mk_inst(3'd0, 5'd0, 5'd1, 5'd2, 7'h0B);
    lqid     = 3'd0;
    lq_rdy   = 1'b1;
    tick();
    tick();
    inst_vld = 1'b0;
    chk("reset_rdy", {31'd0, inst_rdy}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_outs", {rden, rdaddr, ab_valid, c_valid, op_addr, c_addr, lqvld, lqid_o, lqexc}, 32'd0);
    rst_n = 1'b1;
    tick();

    // MOPACC md=1 vs1=3 vs2=7
    exp_q.push_back(ev_rd(3'b110, {5'd3, 5'd7, 5'd0}));
    exp_q.push_back(ev_ab(1'b1));
    issue(mk_inst(3'd0, 5'd1, 5'd3, 5'd7, 7'h0B), 3'd4);
    chk("mop_c1_rdy", {31'd0, inst_rdy}, 32'd0);
    chk("mop_c1_rden", {29'd0, rden}, 32'd6);
    tick();
    chk("mop_c2_ab", {31'd0, ab_valid}, 32'd1);
    tick();
    chk("mop_c3_rdy", {31'd0, inst_rdy}, 32'd1);

    // back-to-back MOPACC accepted in the first idle cycle
    exp_q.push_back(ev_rd(3'b110, {5'd31, 5'd0, 5'd0}));
    exp_q.push_back(ev_ab(1'b0));
    issue(mk_inst(3'd0, 5'd0, 5'd31, 5'd0, 7'h0B), 3'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    count_busy(n);
    chk("b2b_busy_len", n, 32'd2);

    // MMV.V.M md=0 lqid=6, no stall
    for (int r = 0; r < 4; r++) exp_q.push_back(ev_lq(1'b0, 3'(6 + r), 1'b0, 2'(r)));
    issue(mk_inst(3'd1, 5'd0, 5'd0, 5'd0, 7'h0B), 3'd6);
    count_busy(n);
    chk("out_busy_len", n, 32'd4);

    // same MMV.V.M with a 3-cycle stall on row 2
    exp_q.push_back(ev_lq(1'b0, 3'd6, 1'b0, 2'd0));
    exp_q.push_back(ev_lq(1'b0, 3'd7, 1'b0, 2'd1));
    for (int k = 0; k < 4; k++) exp_q.push_back(ev_lq(1'b0, 3'd0, 1'b0, 2'd2));
    exp_q.push_back(ev_lq(1'b0, 3'd1, 1'b0, 2'd3));
`ifdef TT_MPU_SEQ_PERF_EN
    st0 = perf_st;
`endif
    issue(mk_inst(3'd1, 5'd0, 5'd0, 5'd0, 7'h0B), 3'd6);
    tick();
    tick();
    lq_rdy = 1'b0;
    tick();
    tick();
    tick();
    lq_rdy = 1'b1;
    count_busy(n);
    chk("stall_tail", n, 32'd2);
`ifdef TT_MPU_SEQ_PERF_EN
    chk("perf_stall", perf_st - st0, 32'd3);
    chk("perf_opacc", perf_op, 32'd2);
`endif

    // MMV.M.V md=1 vs1=30
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(ev_rd(3'b001, {10'd0, 5'(30 + r)}));
      exp_q.push_back(ev_cv(1'b1, 2'(r)));
    end
    issue(mk_inst(3'd2, 5'd1, 5'd30, 5'd0, 7'h0B), 3'd0);
    count_busy(n);
    chk("in_busy_len", n, 32'd8);

    // illegal: funct3=5, md=2, bad opcode
    exp_q.push_back(ev_lq(1'b1, 3'd3, 1'b0, 2'd0));
    issue(mk_inst(3'd5, 5'd0, 5'd1, 5'd2, 7'h0B), 3'd3);
    count_busy(n);
    chk("exc_f3_len", n, 32'd1);
    exp_q.push_back(ev_lq(1'b1, 3'd5, 1'b0, 2'd0));
    issue(mk_inst(3'd0, 5'd2, 5'd1, 5'd2, 7'h0B), 3'd5);
    count_busy(n);
    chk("exc_md_len", n, 32'd1);
    exp_q.push_back(ev_lq(1'b1, 3'd2, 1'b0, 2'd0));
    lq_rdy = 1'b0;
    issue(mk_inst(3'd0, 5'd0, 5'd1, 5'd2, 7'h33), 3'd2);
    exp_q.push_back(ev_lq(1'b1, 3'd2, 1'b0, 2'd0));
    tick();
    lq_rdy = 1'b1;
    count_busy(n);
    chk("exc_opc_tail", n, 32'd1);

    // reset during OUT row 1
    exp_q.push_back(ev_lq(1'b0, 3'd2, 1'b0, 2'd0));
    exp_q.push_back(ev_lq(1'b0, 3'd3, 1'b0, 2'd1));
    issue(mk_inst(3'd1, 5'd0, 5'd0, 5'd0, 7'h0B), 3'd2);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_rdy", {31'd0, inst_rdy}, 32'd1);
    chk("rst_mid_outs", {rden, rdaddr, ab_valid, c_valid, op_addr, c_addr, lqvld, lqid_o, lqexc}, 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(ev_rd(3'b110, {5'd4, 5'd5, 5'd0}));
    exp_q.push_back(ev_ab(1'b1));
    issue(mk_inst(3'd0, 5'd1, 5'd4, 5'd5, 7'h0B), 3'd0);
    count_busy(n);
    chk("post_rst_mop_len", n, 32'd2);

    repeat (4) tick();
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
